// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO: read-mode encoding and the
// helpers that turn an address width into a depth and a pointer width.
// ---------------------------------------------------------------------------
package fifo_pkg;

   // Read-mode encoding for the FWFT parameter of sync_fifo_ram.
   typedef enum logic {
      FWFT_OFF = 1'b0,   // registered read on request
      FWFT_ON  = 1'b1    // first-word-fall-through
   } fwft_mode_e;

   // Number of words addressed by an address of the given width.
   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Single-clock simple dual-port RAM: one write port, one read port with a
// registered output. There is no reset, so the array and the output register
// keep their contents across a FIFO reset.
//
// Ports
//   clk_i     : clock, rising edge
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   re_i      : read enable; rdata_o updates only when set
//   raddr_i   : read address
//   rdata_o   : registered read data
// ---------------------------------------------------------------------------
module fifo_mem #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// Single-clock FIFO built on fifo_mem, with registered status flags, a word
// count and sticky overflow/underflow flags. Two read modes:
//   FWFT=0 : a read accepted at an edge shows its word on rdata with a
//            one-cycle rvalid pulse after the following edge; rdata holds.
//   FWFT=1 : the head word is prefetched into rdata (rvalid=1, empty=0);
//            rd_en pops it and the next word appears at the same edge.
//
// Ports
//   w_clk, w_rst           : clock and synchronous active-high reset
//   wr_en, wdata           : write request and data
//   rd_en                  : read request (FWFT=1: pop head word)
//   rdata, rvalid          : read data and its valid flag
//   full, empty            : status flags
//   almost_full            : count >= AFULL_TH
//   almost_empty           : count <= AEMPTY_TH
//   count                  : words held (FWFT=1 includes the word in rdata)
//   overflow, underflow    : sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module sync_fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_TH   = fifo_depth(ADDR_WIDTH) - 2,
   parameter int AEMPTY_TH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                  w_clk,
   input  logic                  w_rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int            DEPTH    = fifo_depth(ADDR_WIDTH);
   localparam int            CW       = ptr_width(ADDR_WIDTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
   localparam bit            IS_FWFT  = (FWFT == int'(FWFT_ON));

   if (AFULL_TH > DEPTH || AEMPTY_TH >= DEPTH || AFULL_TH < 0 || AEMPTY_TH < 0
       || (FWFT != 0 && FWFT != 1)) begin : g_bad_params
      $error("sync_fifo_ram: need 0<=AFULL_TH<=DEPTH, 0<=AEMPTY_TH<DEPTH, FWFT in {0,1}");
   end

   logic [CW-1:0]         wptr_q, rptr_q, count_q;
   logic [CW-1:0]         wptr_d, rptr_d, count_d, avail_d;
   logic                  full_q, empty_q, afull_q, aempty_q;
   logic                  rvalid_q, rd_pend_q, loaded_q;
   logic                  ovf_q, udf_q;
   logic [DATA_WIDTH-1:0] rdata_q, mem_rdata;
   logic                  wr_acc, rd_acc, prefetch_d, mem_re;
   logic [ADDR_WIDTH-1:0] mem_raddr;

   always_comb begin
      wr_acc  = wr_en & ~full_q;
      rd_acc  = rd_en & ~empty_q;
      wptr_d  = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
      rptr_d  = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
      count_d = wptr_d - rptr_d;
      // Words already in the RAM before this edge, after this edge's pop.
      // A word written at this edge is not yet readable, so FWFT shows it
      // one edge later; this also keeps the RAM read off the write address.
      avail_d    = count_q - {{ADDR_WIDTH{1'b0}}, rd_acc};
      prefetch_d = (avail_d != '0);
      // FWFT reads the new head every cycle it exists; FWFT=0 reads on request.
      mem_re    = IS_FWFT ? prefetch_d : rd_acc;
      mem_raddr = IS_FWFT ? rptr_d[ADDR_WIDTH-1:0] : rptr_q[ADDR_WIDTH-1:0];
   end

   fifo_mem #(
      .DW (DATA_WIDTH),
      .AW (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (w_clk),
      .we_i    (wr_acc),
      .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (wdata),
      .re_i    (mem_re),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         afull_q   <= (AFULL_TH == 0);
         aempty_q  <= 1'b1;
         rvalid_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         loaded_q  <= 1'b0;
         rdata_q   <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == DEPTH_C);
         afull_q  <= (count_d >= AFULL_C);
         aempty_q <= (count_d <= AEMPTY_C);
         if (wr_en && full_q) begin
            ovf_q <= 1'b1;
         end
         if (rd_en && empty_q) begin
            udf_q <= 1'b1;
         end
         if (IS_FWFT) begin
            rvalid_q <= prefetch_d;
            empty_q  <= ~prefetch_d;
            if (prefetch_d) begin
               loaded_q <= 1'b1;
            end
         end else begin
            // RAM output lands one edge after the accept; copy it into the
            // resettable output register one edge later.
            rd_pend_q <= rd_acc;
            rvalid_q  <= rd_pend_q;
            empty_q   <= (count_d == '0);
            if (rd_pend_q) begin
               rdata_q <= mem_rdata;
            end
         end
      end
   end

   // In FWFT mode the RAM output register is the data register; it has no
   // reset, so it reads as zero until the first word has been fetched.
   assign rdata        = IS_FWFT ? (loaded_q ? mem_rdata : '0) : rdata_q;
   assign rvalid       = rvalid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo_ram.md
SYNC_FIFO_RAM -- requirements
Module: sync_fifo_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, pointer width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost_full asserts when count >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost_empty asserts when count <= AEMPTY_TH.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read on request, 1 = first-word-fall-through.
REQ-006 SHALL have port w_clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port w_rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rd_en  input  1  read request (FWFT=1: pop of head word).
REQ-011 SHALL have port rdata  output  DATA_WIDTH  read data, registered.
REQ-012 SHALL have port rvalid  output  1  rdata holds a valid word.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags, registered.
REQ-014 SHALL have port count  output  ADDR_WIDTH+1  words held (FWFT=1: includes word in rdata).
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write SHALL be accepted iff wr_en=1 and full=0; word stored at write pointer, pointer increments, wraps DEPTH-1 -> 0.
REQ-017 Read SHALL be accepted iff rd_en=1 and empty=0; pointers are ADDR_WIDTH+1 bits, MSB distinguishes full from empty.
REQ-018 Simultaneous accepted write and read SHALL leave count unchanged; full blocks the write even if a read is accepted in the same cycle.
REQ-019 FWFT=0: accepted read at edge N SHALL present head word on rdata with rvalid=1 after edge N+1... i.e. one-cycle latency; rvalid is a one-cycle pulse; rdata holds last value otherwise.
REQ-020 FWFT=1: head word SHALL be prefetched into rdata; write into empty FIFO at edge N gives rvalid=1 after edge N+1; empty = !rvalid; accepted pop updates rdata with next word (or deasserts rvalid) at same edge.
REQ-021 Write to a full FIFO SHALL be dropped and set overflow; read of empty FIFO SHALL be ignored and set underflow; both stay set until reset.
REQ-022 Flags and count SHALL reflect all operations accepted up to and including the current edge, with no combinational path from wr_en/rd_en to any output.
REQ-023 Read of an address being written in the same cycle SHALL never occur (empty prevents it); no read-during-write bypass is required.

Reset
REQ-024 On w_rst=1 at a rising edge: pointers, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AFULL_TH=0), rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-025 Reset mid-operation SHALL discard all stored words; wr_en/rd_en in the reset cycle SHALL be ignored; memory array contents SHALL not be cleared.

Structure
REQ-026 Pointer-width/depth helper constants and the FWFT mode encoding SHALL live in shared package fifo_pkg.
REQ-027 Storage SHALL be a sub-module fifo_mem (single-clock simple dual-port RAM, write enable, registered read with read enable, no reset); flag/pointer logic stays in sync_fifo_ram.
REQ-028 Parameter check SHALL reject AFULL_TH > DEPTH or AEMPTY_TH >= DEPTH at elaboration.

Verification
REQ-029 Defaults, FWFT=0: write 0x01..0x10 (16 words) -> full=1, count=16 after 16th edge; 17th write (0xAA) -> overflow=1, count stays 16.
REQ-030 Continuing: 16 reads -> rdata 0x01..0x10 in order, each one cycle after its rd_en; then empty=1; extra read -> underflow=1, rvalid stays 0.
REQ-031 Pointer wrap: 12 writes, 12 reads, 12 writes, 12 reads -> data order preserved across wrap, count returns to 0.
REQ-032 Simultaneous: count=5, wr_en=rd_en=1 for 10 cycles -> count stays 5, almost flags unchanged, data order preserved.
REQ-033 FWFT=1: write 0x5A to empty FIFO at edge N -> rvalid=1, rdata=0x5A after edge N+1, count=1; pop -> rvalid=0, empty=1.
REQ-034 Reset with count=9 and overflow=1 -> next cycle count=0, empty=1, overflow=0, rvalid=0; subsequent write/read returns new data only.
